// File: rtl/inv_clarke_if.sv
// Sample bus for the inverse Clarke stage: alpha/beta command in, three phase voltages out.
interface inv_clarke_if #(
  parameter int W = 32
);
  logic signed [W-1:0] valp;
  logic signed [W-1:0] vbet;
  logic signed [W-1:0] va;
  logic signed [W-1:0] vb;
  logic signed [W-1:0] vc;
  logic                out_vld;

  modport master (
    output valp, vbet,
    input  va, vb, vc, out_vld
  );

  modport slave (
    input  valp, vbet,
    output va, vb, vc, out_vld
  );
endinterface

// File: rtl/inv_clarke.sv
// Inverse Clarke transform (alpha, beta) -> (a, b, c); 2-cycle latency, one sample per clock.
// Free-running: no backpressure, out_vld only marks the pipeline as filled after reset.
module inv_clarke #(
  parameter int W  = 32,
  parameter int KF = 16,
  parameter int K  = 56756
) (
  input  logic         clk,
  input  logic         rst_n,
  inv_clarke_if.slave  bus
);

  localparam int PW = W + KF + 1;
  localparam int SW = W + 2;

  localparam logic [KF-1:0]        KU   = KF'(K);
  localparam logic signed [SW-1:0] SMAX = SW'({1'b0, {(W-1){1'b1}}});
  localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);
  localparam logic signed [W-1:0]  OMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  OMIN = {1'b1, {(W-1){1'b0}}};

  function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] x);
    logic signed [W-1:0] r;
    if (x > SMAX) begin
      r = OMAX;
    end else if (x < SMIN) begin
      r = OMIN;
    end else begin
      r = W'(x);
    end
    return r;
  endfunction

  // Stage 1: alpha pass-through, half alpha, scaled beta
  logic signed [PW-1:0] vbet_x;
  logic signed [PW-1:0] k_x;
  logic signed [PW-1:0] prod;

  logic signed [W-1:0]  a_q, a_d;
  logic signed [W-1:0]  h_q, h_d;
  logic signed [W:0]    t_q, t_d;

  assign vbet_x = PW'(bus.vbet);
  assign k_x    = PW'($signed({1'b0, KU}));
  assign prod   = vbet_x * k_x;

  always_comb begin
    a_d = bus.valp;
    h_d = bus.valp >>> 1;
    t_d = (W+1)'(prod >>> KF);
  end

  // Stage 2: combine at W+2 bits, then clamp b and c; a is never clamped
  logic signed [SW-1:0] hx, tx, vb_w, vc_w;
  logic signed [W-1:0]  va_q, va_d;
  logic signed [W-1:0]  vb_q, vb_d;
  logic signed [W-1:0]  vc_q, vc_d;

  always_comb begin
    hx   = SW'(h_q);
    tx   = SW'(t_q);
    vb_w = tx - hx;
    vc_w = -hx - tx;
    va_d = a_q;
    vb_d = sat(vb_w);
    vc_d = sat(vc_w);
  end

  // Warm-up counter saturates at 2 once both stages hold real samples
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != 2'd2) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_q   <= '0;
      h_q   <= '0;
      t_q   <= '0;
      va_q  <= '0;
      vb_q  <= '0;
      vc_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      a_q   <= a_d;
      h_q   <= h_d;
      t_q   <= t_d;
      va_q  <= va_d;
      vb_q  <= vb_d;
      vc_q  <= vc_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.va      = va_q;
  assign bus.vb      = vb_q;
  assign bus.vc      = vc_q;
  assign bus.out_vld = (cnt_q == 2'd2);

endmodule

// File: tb/tb_inv_clarke.sv
// Scoreboard bench for inv_clarke: stimulus pushes expected triples, a negedge monitor pops and compares.
module tb_inv_clarke;

  typedef struct {
    logic signed [31:0] va;
    logic signed [31:0] vb;
    logic signed [31:0] vc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  inv_clarke_if #(.W(32)) bus ();

  inv_clarke #(.W(32), .KF(16), .K(56756)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int ND = 8;
  logic signed [31:0] d_a  [ND] = '{32'sd70, 32'sd70, 32'sh7FFFFFFF, 32'sh80000000, 32'sd0, -32'sd1, 32'sd3, -32'sd3};
  logic signed [31:0] d_b  [ND] = '{32'sd86, -32'sd86, 32'sh7FFFFFFF, 32'sh80000000, 32'sd0, 32'sd0, 32'sd65536, -32'sd1};
  logic signed [31:0] d_ea [ND] = '{32'sd70, 32'sd70, 32'sh7FFFFFFF, 32'sh80000000, 32'sd0, -32'sd1, 32'sd3, -32'sd3};
  logic signed [31:0] d_eb [ND] = '{32'sd39, -32'sd110, 32'sd786038784, -32'sd786038784, 32'sd0, 32'sd1, 32'sd56755, 32'sd1};
  logic signed [31:0] d_ec [ND] = '{-32'sd109, 32'sd40, 32'sh80000000, 32'sh7FFFFFFF, 32'sd0, 32'sd1, -32'sd56757, 32'sd3};

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  function automatic logic signed [31:0] clamp(input longint x);
    logic signed [31:0] r;
    if (x > 64'sd2147483647) r = 32'sh7FFFFFFF;
    else if (x < -64'sd2147483648) r = 32'sh80000000;
    else r = 32'(x);
    return r;
  endfunction

  function automatic exp_t model(input logic signed [31:0] a, input logic signed [31:0] b);
    longint h, t;
    exp_t r;
    h = longint'(a) >>> 1;
    t = (longint'(b) * 64'sd56756) >>> 16;
    r.va = a;
    r.vb = clamp(t - h);
    r.vc = clamp(-h - t);
    return r;
  endfunction

  task automatic step_exp(input logic signed [31:0] a, input logic signed [31:0] b,
                          input logic signed [31:0] ea, input logic signed [31:0] eb,
                          input logic signed [31:0] ec);
    exp_t e;
    e.va = ea;
    e.vb = eb;
    e.vc = ec;
    bus.valp = a;
    bus.vbet = b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic signed [31:0] a, input logic signed [31:0] b);
    exp_t e;
    e = model(a, b);
    step_exp(a, b, e.va, e.vb, e.vc);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_va"}, bus.va, 32'sd0);
    chk({tag, "_vb"}, bus.vb, 32'sd0);
    chk({tag, "_vc"}, bus.vc, 32'sd0);
    chk({tag, "_vld"}, 32'(bus.out_vld), 32'sd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b0 && bus.out_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: va=%0d vb=%0d vc=%0d with nothing expected", bus.va, bus.vb, bus.vc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("mon_va", bus.va, mon_e.va);
        chk("mon_vb", bus.vb, mon_e.vb);
        chk("mon_vc", bus.vc, mon_e.vc);
      end
    end
  end

  initial begin
    rst_n    = 1'b1;
    bus.valp = 32'sd123456;
    bus.vbet = -32'sd98765;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_zero("reset_hold");
    end

    // Release and run the directed table, each vector held three cycles
    rst_n = 1'b0;
    for (int i = 0; i < ND; i++) begin
      for (int r = 0; r < 3; r++) begin
        step_exp(d_a[i], d_b[i], d_ea[i], d_eb[i], d_ec[i]);
        if (i == 0 && r == 0) chk("vld_after_edge1", 32'(bus.out_vld), 32'sd0);
        if (i == 0 && r == 1) chk("vld_after_edge2", 32'(bus.out_vld), 32'sd1);
      end
    end

    for (int i = 0; i < 40; i++) begin
      step($urandom, $urandom);
    end
    step(32'sd1000, 32'sd2000);

    // Asynchronous reset between edges
    #2;
    chk("pending_before_reset", sb_q.size(), 32'sd2);
    rst_n = 1'b1;
    sb_q.delete();
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    #1;
    chk_zero("reset_one_cycle");

    rst_n = 1'b0;
    step(32'sd70, 32'sd86);
    chk("refill_vld_edge1", 32'(bus.out_vld), 32'sd0);
    step(-32'sd5000, 32'sd7777);
    chk("refill_vld_edge2", 32'(bus.out_vld), 32'sd1);
    for (int i = 0; i < 10; i++) begin
      step($urandom_range(2000, 0) - 1000, $urandom_range(2000, 0) - 1000);
    end

    for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #2;
    end
    rst_n = 1'b1;
    chk("drain_empty", sb_q.size(), 32'sd0);
    #1;
    chk_zero("final_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
